// File: rtl/ifu_litebpu_pkg.sv
// Shared widths and jalr-xN state encodings for the IFU lite branch predictor.
package ifu_litebpu_pkg;

   localparam int DEF_XLEN        = 32;
   localparam int DEF_PC_SIZE     = 32;
   localparam int DEF_RFIDX_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_DEP = 2'd1,
      RS1_RD   = 2'd2,
      RS1_HOLD = 2'd3
   } rs1_state_e;

endpackage

// File: rtl/ifu_litebpu_rs1fsm.sv
// jalr xN base-operand sequencer: waits out hazards, issues one shared-port read,
// and keeps the returned value in a holding register for the prediction adder.
module ifu_litebpu_rs1fsm
   import ifu_litebpu_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            jalr_xn,
   input  logic            dep_xn,
   input  logic            flush,
   input  logic            handoff,
   input  logic [XLEN-1:0] rs1_data,
   output logic            rd_ena,
   output logic            fsm_wait,
   output logic [XLEN-1:0] hold_val
);

   rs1_state_e      state_reg;
   rs1_state_e      state_next;
   logic            capture;
   logic [XLEN-1:0] hold_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            hold_reg <= rs1_data;
         end
      end
   end

   // Losing the jalr (valid drop or class change) or a flush always abandons the sequence.
   always_comb begin
      state_next = state_reg;
      rd_ena     = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (jalr_xn && !flush) begin
               if (dep_xn) begin
                  state_next = WAIT_DEP;
               end else begin
                  rd_ena     = 1'b1;
                  state_next = RS1_RD;
               end
            end
         end
         WAIT_DEP: begin
            if (flush || !jalr_xn) begin
               state_next = IDLE;
            end else if (!dep_xn) begin
               rd_ena     = 1'b1;
               state_next = RS1_RD;
            end
         end
         RS1_RD: begin
            if (flush || !jalr_xn) begin
               state_next = IDLE;
            end else begin
               capture    = 1'b1;
               state_next = RS1_HOLD;
            end
         end
         RS1_HOLD: begin
            if (flush || !jalr_xn || handoff) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign fsm_wait = (state_reg != RS1_HOLD);
   assign hold_val = hold_reg;

endmodule

// File: rtl/ifu_litebpu.sv
// Static branch predictor / next-PC generator: branch-class mux, jalr base
// selection with hazard stalls, and a single shared PC adder.
module ifu_litebpu
   import ifu_litebpu_pkg::*;
#(
   parameter int XLEN        = DEF_XLEN,
   parameter int PC_SIZE     = DEF_PC_SIZE,
   parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PC_SIZE-1:0]     ifu_pc,
   input  logic                   dec_i_valid,
   input  logic                   dec_jal,
   input  logic                   dec_jalr,
   input  logic                   dec_bxx,
   input  logic [XLEN-1:0]        dec_bjp_imm,
   input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
   input  logic                   ir_valid,
   input  logic                   ir_ready,
   input  logic                   ir_rs1en,
   input  logic                   ir_rdwen,
   input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
   input  logic                   oitf_empty,
   input  logic                   flush,
   input  logic [XLEN-1:0]        rf2bpu_x1,
   input  logic [XLEN-1:0]        rf2bpu_rs1,
   output logic                   bpu2rf_rs1_ena,
   output logic                   bpu_wait,
   output logic                   prdt_taken,
   output logic [PC_SIZE-1:0]     prdt_pc
);

   logic               active;
   logic               is_jal;
   logic               is_jalr;
   logic               is_bxx;
   logic               jalr_x0;
   logic               jalr_x1;
   logic               jalr_xn;
   logic               dep_x1;
   logic               dep_xn;
   logic               ir_rd_hazard;
   logic               ir_port_busy;
   logic               fsm_wait;
   logic               rd_ena;
   logic               handoff;
   logic [XLEN-1:0]    hold_val;
   logic [PC_SIZE-1:0] jalr_base;
   logic [PC_SIZE-1:0] add_op1;
   logic [PC_SIZE-1:0] add_res;

   assign active  = dec_i_valid & ~rst;
   assign is_jal  = dec_jal;
   assign is_jalr = dec_jalr & ~dec_jal;
   assign is_bxx  = dec_bxx & ~dec_jal & ~dec_jalr;

   assign jalr_x0 = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
   assign jalr_x1 = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
   assign jalr_xn = active & is_jalr & ~jalr_x0 & ~jalr_x1;

   assign dep_x1 = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == RFIDX_WIDTH'(1)));

   // Any valid IR instruction blocks the xN read: either it may write the register
   // or it may be using the shared read port; ir_valid alone already covers both.
   assign ir_rd_hazard = ir_valid & ir_rdwen;
   assign ir_port_busy = ir_valid & ir_rs1en;
   assign dep_xn       = ~oitf_empty | ir_rd_hazard | ir_port_busy | ir_valid;

   assign handoff = dec_i_valid & ~bpu_wait & ir_ready;

   ifu_litebpu_rs1fsm #(
      .XLEN(XLEN)
   ) u_rs1fsm (
      .clk      (clk),
      .rst      (rst),
      .jalr_xn  (jalr_xn),
      .dep_xn   (dep_xn),
      .flush    (flush),
      .handoff  (handoff),
      .rs1_data (rf2bpu_rs1),
      .rd_ena   (rd_ena),
      .fsm_wait (fsm_wait),
      .hold_val (hold_val)
   );

   always_comb begin
      jalr_base = hold_val[PC_SIZE-1:0];
      if (jalr_x0) begin
         jalr_base = '0;
      end else if (jalr_x1) begin
         jalr_base = rf2bpu_x1[PC_SIZE-1:0];
      end
   end

   assign add_op1 = is_jalr ? jalr_base : ifu_pc;
   assign add_res = add_op1 + dec_bjp_imm[PC_SIZE-1:0];

   assign prdt_taken = active & (is_jal | is_jalr | (is_bxx & dec_bjp_imm[XLEN-1]));
   assign prdt_pc    = prdt_taken ? add_res : '0;

   always_comb begin
      bpu_wait = 1'b0;
      if (active && is_jalr) begin
         if (jalr_x1) begin
            bpu_wait = dep_x1;
         end else if (!jalr_x0) begin
            bpu_wait = fsm_wait;
         end
      end
   end

   assign bpu2rf_rs1_ena = rd_ena & ~flush & ~rst;

endmodule
